conv_line_buffer: RTL
=====================

CONV_LINE_BUFFER -- requirements
Module: conv_line_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 SHALL have parameter KERNEL_SIZE, default 3: window edge; window holds KERNEL_SIZE*KERNEL_SIZE = 9 pixels.
REQ-003 SHALL have parameter ROW_LEN, default 320: pixels per image row.
REQ-004 SHALL have parameter ROW_NUM, default 240: rows per frame.
REQ-005 SHALL have port clk, input, 1: single clock; all logic is rising-edge triggered.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port pix_in, input, DATA_WIDTH: raster-order pixel stream.
REQ-008 SHALL have port pix_valid_in, input, 1: pix_in is accepted this cycle; there is no backpressure.
REQ-009 SHALL have port frame_clr, input, 1: synchronous abort/restart of the current frame.
REQ-010 SHALL have port win_data_out, output, 9*DATA_WIDTH: 3x3 window; feeds the convolution data input directly.
REQ-011 SHALL have port win_valid_out, output, 1: win_data_out is valid this cycle.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse marking the last window of a frame.
REQ-013 SHALL have port busy, output, 1: high while a frame is partially received.

Function
REQ-014 SHALL keep a column counter (0..ROW_LEN-1) and a row counter (0..ROW_NUM-1) that advance only on cycles with pix_valid_in=1.
- Column wraps ROW_LEN-1 -> 0 and increments the row.
- Row wraps ROW_NUM-1 -> 0 together with the column wrap.
REQ-015 SHALL store the two most recent complete rows in two circular line RAMs of depth ROW_LEN, addressed by the column counter.
- On each accepted pixel: line0 is read into line1 at the same address, and pix_in is written into line0 (read-before-write).
REQ-016 SHALL keep a 3x3 shift register. On each accepted pixel, every row shifts left by one, and the new right column is {line1[col], line0[col], pix_in} (top to bottom).
REQ-017 SHALL pack window element k = r*3+c (r = row, 0 = top; c = column, 0 = left) at bits [k*DATA_WIDTH +: DATA_WIDTH]. Element 8 is the newest pixel.
REQ-018 SHALL assert win_valid_out exactly one cycle after accepting a pixel with row>=2 and col>=2.
- Windows are unpadded ("valid" convolution): ROW_LEN-2 windows per row and (ROW_LEN-2)*(ROW_NUM-2) windows per frame.
REQ-019 SHALL hold win_data_out stable when win_valid_out=0. Its content is don't-care but must not change without an accepted pixel.
REQ-020 SHALL run a state machine with these states:
- FILL (row<2): no windows produced.
- STREAM (row>=2): windows produced.
- FILL -> STREAM on the column wrap into row 2.
- STREAM -> FILL on the frame wrap.
REQ-021 SHALL pulse frame_done in the same cycle as the win_valid_out produced by pixel (ROW_NUM-1, ROW_LEN-1).
REQ-022 SHALL drive busy=1 from the first accepted pixel of a frame until the cycle after the last pixel is accepted.
REQ-023 SHALL, on frame_clr=1:
- zero both counters, enter FILL, and force win_valid_out, frame_done and busy to 0 next cycle;
- leave RAM contents as don't-care;
- give frame_clr priority over a simultaneous pix_valid_in, so that pixel is dropped.
REQ-024 SHALL treat gaps in pix_valid_in (any length, any position, including mid-row) as pure stalls with no effect on output ordering or values.
REQ-025 SHALL allow back-to-back frames with no idle cycle. The first pixel of the next frame is accepted in the cycle after the last pixel of the previous frame.

Reset
REQ-026 SHALL, while rst=1, asynchronously clear:
- counters to 0;
- state to FILL;
- win_valid_out, frame_done and busy to 0;
- win_data_out and the shift register to 0.
REQ-027 SHALL leave line-RAM contents uninitialised by reset. They are always overwritten before being used in a valid window.

Structure
REQ-028 SHALL take DATA_WIDTH, KERNEL_SIZE, ROW_LEN, ROW_NUM defaults and the state encoding (FILL=0, STREAM=1) from the shared package cnn_pkg.
REQ-029 SHALL implement each line buffer as an instance of one sub-module, line_ram:
- single clock, depth ROW_LEN, DATA_WIDTH wide;
- synchronous read, read-before-write on the same address;
- counter widths derived by clog2 of ROW_LEN and ROW_NUM.

Verification (ROW_LEN=8, ROW_NUM=4, pixel = row*16+col)
REQ-030 Continuous frame -> exactly 12 win_valid_out. First window elements 0..8 = 00,01,02,10,11,12,20,21,22 (hex). frame_done only with the last window, whose elements are 15,16,17,25,26,27,35,36,37.
REQ-031 Same frame with pix_valid_in randomly low 50% of cycles -> identical 12 windows in the same order; no valid while stalled.
REQ-032 Two frames back-to-back, second frame pixel = 0x80+row*16+col -> 24 windows. The second frame's first window is 80,81,82,90,91,92,A0,A1,A2; there is no window at a frame boundary.
REQ-033 frame_clr asserted together with pix_valid_in at pixel (2,5) -> next cycle valid=0 and busy=0. A fresh full frame then yields exactly 12 correct windows.
REQ-034 rst pulsed asynchronously mid-row in STREAM -> outputs 0 immediately. After release, a full frame yields 12 correct windows.
REQ-035 Single-row stream (8 pixels), then idle 20 cycles -> no win_valid_out, busy=1 held throughout.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN datapath defaults and line-buffer state encoding
package cnn_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_ROW_LEN = 320;
  localparam int DEF_ROW_NUM = 240;
  typedef enum logic {FILL = 1'b0, STREAM = 1'b1} lb_state_t;
endpackage

// File: rtl/line_ram.sv
// line_ram: single-clock line buffer with synchronous read, read-before-write
module line_ram
  import cnn_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_ROW_LEN,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: raster pixel stream to 3x3 sliding windows over two line RAMs
module conv_line_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int ROW_LEN = DEF_ROW_LEN,
  parameter int ROW_NUM = DEF_ROW_NUM
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [DATA_WIDTH-1:0]                         pix_in,
  input  logic                                          pix_valid_in,
  input  logic                                          frame_clr,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win_data_out,
  output logic                                          win_valid_out,
  output logic                                          frame_done,
  output logic                                          busy
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(ROW_LEN);
  localparam int RW = $clog2(ROW_NUM);
  lb_state_t state;
  logic [CW-1:0] col, col_nxt;
  logic [RW-1:0] row;
  logic [DW-1:0] l0_q, l1_q;
  logic [DW-1:0] new_col [3];
  logic [KERNEL_SIZE*KERNEL_SIZE*DW-1:0] win_nxt;
  logic acc, col_end, row_end;
  assign acc = pix_valid_in && !frame_clr;
  assign col_end = col == CW'(ROW_LEN - 1);
  assign row_end = row == RW'(ROW_NUM - 1);
  // RAMs are read one column ahead so their output is ready when the next pixel lands
  assign col_nxt = frame_clr ? '0 : !acc ? col : col_end ? '0 : col + 1'b1;
  assign new_col[0] = l1_q;
  assign new_col[1] = l0_q;
  assign new_col[2] = pix_in;
  line_ram #(.WIDTH(DW), .DEPTH(ROW_LEN)) u_line0 (
    .clk(clk), .we(acc), .waddr(col), .wdata(pix_in), .raddr(col_nxt), .rdata(l0_q)
  );
  line_ram #(.WIDTH(DW), .DEPTH(ROW_LEN)) u_line1 (
    .clk(clk), .we(acc), .waddr(col), .wdata(l0_q), .raddr(col_nxt), .rdata(l1_q)
  );
  for (genvar k = 0; k < KERNEL_SIZE*KERNEL_SIZE; k++) begin : g_win
    if (k % KERNEL_SIZE == KERNEL_SIZE - 1) begin : g_new
      assign win_nxt[k*DW +: DW] = new_col[k / KERNEL_SIZE];
    end else begin : g_shift
      assign win_nxt[k*DW +: DW] = win_data_out[(k+1)*DW +: DW];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) win_data_out <= '0;
    else if (acc) win_data_out <= win_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      state <= FILL;
      win_valid_out <= 1'b0;
      frame_done <= 1'b0;
      busy <= 1'b0;
    end else if (frame_clr) begin
      col <= '0;
      row <= '0;
      state <= FILL;
      win_valid_out <= 1'b0;
      frame_done <= 1'b0;
      busy <= 1'b0;
    end else begin
      win_valid_out <= acc && state == STREAM && col >= CW'(KERNEL_SIZE - 1);
      frame_done <= acc && state == STREAM && row_end && col_end;
      if (acc) begin
        col <= col_nxt;
        busy <= !(row_end && col_end);
        if (col_end) row <= row_end ? '0 : row + 1'b1;
        if (col_end && row_end) state <= FILL;
        else if (col_end && row == RW'(KERNEL_SIZE - 2)) state <= STREAM;
      end
    end
  end
endmodule
